// File: rtl/axi_hp_responder_pkg.sv
// Shared definitions for the HP-port burst responder.
//   - AXI response and burst encodings
//   - write / read FSM state types
//   - burst legality helper (only FIXED/INCR with 8-byte beats are served)
package axi_hp_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  // log2 of the 64-bit beat size in bytes
  localparam logic [2:0] SIZE_64 = 3'd3;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  function automatic logic burst_ok(input logic [1:0] burst, input logic [2:0] size);
    return (burst != BURST_WRAP) && (burst != BURST_RSVD) && (size == SIZE_64);
  endfunction

endpackage

// File: rtl/axi_hp_responder_ram.sv
// hp_ram_sdp: simple dual-port 64-bit RAM with byte enables.
//   clk_i            : clock
//   we_i/waddr_i     : write enable / word address
//   wdata_i/wstrb_i  : write data / per-byte lane enables
//   re_i/raddr_i     : read enable / word address
//   rdata_o          : registered read data, 1-cycle latency, holds while re_i=0
// A read and write to the same word in one cycle returns the old contents.
// Contents are never reset.
module hp_ram_sdp #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [63:0]           wdata_i,
  input  logic [7:0]            wstrb_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [63:0]           rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rdata_q;

  // Non-blocking read and write in one block gives read-first behaviour.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
    if (we_i) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_hp_responder.sv
// axi_hp_responder: AXI3 64-bit burst slave backed by a 2^MEM_ADDR_WIDTH x 64 RAM.
//   axi_aclk / axi_aresetn : clock, asynchronous active-low reset
//   s_axi_aw*              : write address channel (prot/cache ignored)
//   s_axi_w*               : write data channel
//   s_axi_b*               : write response channel
//   s_axi_ar*              : read address channel (prot/cache ignored)
//   s_axi_r*               : read data channel
// Write and read sides are independent FSMs. Only FIXED/INCR bursts with
// 8-byte beats touch memory; anything else is drained and answered SLVERR.
module axi_hp_responder
  import axi_hp_responder_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [3:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic [2:0]                s_axi_awprot,
  input  logic [3:0]                s_axi_awcache,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [63:0]               s_axi_wdata,
  input  logic [7:0]                s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [3:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic [2:0]                s_axi_arprot,
  input  logic [3:0]                s_axi_arcache,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [63:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int AW = MEM_ADDR_WIDTH;
  localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

  // Held low through reset and set on the first edge after release, so the
  // address channels never look ready while reset is active.
  logic ready_en_q;

  // Write side
  w_state_e      w_state_q, w_state_d;
  logic [AW-1:0] w_idx_q,   w_idx_d;
  logic [3:0]    w_len_q,   w_len_d;
  logic          w_incr_q,  w_incr_d;
  logic          w_err_q,   w_err_d;
  logic [4:0]    w_cnt_q,   w_cnt_d;   // beats accepted before the current one
  logic [1:0]    bresp_q,   bresp_d;
  logic          ram_we;

  // Read side
  r_state_e      r_state_q, r_state_d;
  logic [AW-1:0] r_idx_q,   r_idx_d;
  logic          r_incr_q,  r_incr_d;
  logic          r_err_q,   r_err_d;
  logic [4:0]    r_left_q,  r_left_d;  // beats still to fetch from RAM
  logic          rvalid_q,  rvalid_d;
  logic          rlast_q,   rlast_d;
  logic [1:0]    rresp_q,   rresp_d;
  logic          ram_re;
  logic [63:0]   ram_rdata;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awprot, s_axi_awcache, s_axi_arprot, s_axi_arcache,
                           s_axi_awaddr, s_axi_araddr};

  always_comb begin
    w_state_d     = w_state_q;
    w_idx_d       = w_idx_q;
    w_len_d       = w_len_q;
    w_incr_d      = w_incr_q;
    w_err_d       = w_err_q;
    w_cnt_d       = w_cnt_q;
    bresp_d       = bresp_q;
    ram_we        = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        s_axi_awready = ready_en_q;
        if (s_axi_awvalid && ready_en_q) begin
          w_idx_d   = s_axi_awaddr[AW+2:3];
          w_len_d   = s_axi_awlen;
          w_incr_d  = (s_axi_awburst != BURST_FIXED);
          w_err_d   = !burst_ok(s_axi_awburst, s_axi_awsize);
          w_cnt_d   = 5'd0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          ram_we = !w_err_q;
          if (w_incr_q) begin
            w_idx_d = w_idx_q + IDX_ONE;
          end
          // Saturate so an overlong burst cannot alias back to a match.
          if (w_cnt_q != 5'h1f) begin
            w_cnt_d = w_cnt_q + 5'd1;
          end
          if (s_axi_wlast) begin
            bresp_d   = (w_err_q || (w_cnt_q != {1'b0, w_len_q})) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read pipeline: the RAM output register is the beat register. A new word
  // is fetched only when the output slot is empty or being consumed, so a
  // stalled beat simply holds in the RAM register.
  always_comb begin
    r_state_d     = r_state_q;
    r_idx_d       = r_idx_q;
    r_incr_d      = r_incr_q;
    r_err_d       = r_err_q;
    r_left_d      = r_left_q;
    rvalid_d      = rvalid_q;
    rlast_d       = rlast_q;
    rresp_d       = rresp_q;
    ram_re        = 1'b0;
    s_axi_arready = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s_axi_arready = ready_en_q;
        if (s_axi_arvalid && ready_en_q) begin
          r_idx_d   = s_axi_araddr[AW+2:3];
          r_incr_d  = (s_axi_arburst != BURST_FIXED);
          r_err_d   = !burst_ok(s_axi_arburst, s_axi_arsize);
          r_left_d  = {1'b0, s_axi_arlen} + 5'd1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && s_axi_rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            r_state_d = R_IDLE;
          end
        end
        if ((r_left_q != 5'd0) && (!rvalid_q || s_axi_rready)) begin
          ram_re   = 1'b1;
          rvalid_d = 1'b1;
          rlast_d  = (r_left_q == 5'd1);
          rresp_d  = r_err_q ? RESP_SLVERR : RESP_OKAY;
          r_left_d = r_left_q - 5'd1;
          if (r_incr_q) begin
            r_idx_d = r_idx_q + IDX_ONE;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      ready_en_q <= 1'b0;
      w_state_q  <= W_IDLE;
      w_idx_q    <= '0;
      w_len_q    <= 4'd0;
      w_incr_q   <= 1'b0;
      w_err_q    <= 1'b0;
      w_cnt_q    <= 5'd0;
      bresp_q    <= RESP_OKAY;
      r_state_q  <= R_IDLE;
      r_idx_q    <= '0;
      r_incr_q   <= 1'b0;
      r_err_q    <= 1'b0;
      r_left_q   <= 5'd0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= RESP_OKAY;
    end else begin
      ready_en_q <= 1'b1;
      w_state_q  <= w_state_d;
      w_idx_q    <= w_idx_d;
      w_len_q    <= w_len_d;
      w_incr_q   <= w_incr_d;
      w_err_q    <= w_err_d;
      w_cnt_q    <= w_cnt_d;
      bresp_q    <= bresp_d;
      r_state_q  <= r_state_d;
      r_idx_q    <= r_idx_d;
      r_incr_q   <= r_incr_d;
      r_err_q    <= r_err_d;
      r_left_q   <= r_left_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rresp_q    <= rresp_d;
    end
  end

  hp_ram_sdp #(
    .ADDR_WIDTH(AW)
  ) u_ram (
    .clk_i   (axi_aclk),
    .we_i    (ram_we),
    .waddr_i (w_idx_q),
    .wdata_i (s_axi_wdata),
    .wstrb_i (s_axi_wstrb),
    .re_i    (ram_re),
    .raddr_i (r_idx_q),
    .rdata_o (ram_rdata)
  );

  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rlast  = rlast_q;
  assign s_axi_rresp  = rresp_q;
  // Error beats and idle cycles present zero rather than stale RAM output.
  assign s_axi_rdata  = (rvalid_q && (rresp_q == RESP_OKAY)) ? ram_rdata : 64'd0;

endmodule
